// File: rtl/lr_shift_feed_if.sv
// Command stream into the shift feed stage and head-of-queue stream toward the shifter.
interface lr_shift_feed_if #(
    parameter int width = 8
);
    localparam int sw = $clog2(width);

    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] in_bits;
    logic [sw:0]      in_shift;
    logic             in_dir;

    logic             sh_valid;
    logic             sh_ready;
    logic [width-1:0] sh_bits;
    logic [sw-1:0]    sh_shift;
    logic             sh_dir;

    modport master (
        output in_valid, in_bits, in_shift, in_dir, sh_ready,
        input  in_ready, sh_valid, sh_bits, sh_shift, sh_dir
    );

    modport slave (
        input  in_valid, in_bits, in_shift, in_dir, sh_ready,
        output in_ready, sh_valid, sh_bits, sh_shift, sh_dir
    );
endinterface

// File: rtl/lr_shift_feed.sv
// Two-entry command FIFO feeding the left/right shifter.
// Over-range shift amounts are folded into an all-zero result at push time.
module lr_shift_feed #(
    parameter int width     = 8,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lr_shift_feed_if.slave       io,
    output logic [cnt_width-1:0] cnt_accepted,
    output logic [cnt_width-1:0] cnt_overrange
);
    localparam int sw = $clog2(width);
    localparam logic [sw:0] wlim = (sw+1)'(width);

    typedef struct packed {
        logic [width-1:0] bits;
        logic [sw-1:0]    shift;
        logic             dir;
    } cmd_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;

    occ_t state;
    cmd_t head, tail, incmd;
    logic sh_valid_q;
    logic push, pop, ovr;

    assign ovr = (io.in_shift >= wlim);

    // A full shift-out is all zeros, so store that directly with a legal amount.
    always_comb begin
        incmd.bits  = ovr ? '0 : io.in_bits;
        incmd.shift = ovr ? '0 : io.in_shift[sw-1:0];
        incmd.dir   = io.in_dir;
    end

    assign pop         = sh_valid_q && io.sh_ready;
    assign io.in_ready = (state != TWO) || pop;
    assign push        = io.in_valid && io.in_ready;

    assign io.sh_valid = sh_valid_q;
    assign io.sh_bits  = head.bits;
    assign io.sh_shift = head.shift;
    assign io.sh_dir   = head.dir;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            head       <= '0;
            tail       <= '0;
            sh_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (push) begin
                    head       <= incmd;
                    state      <= ONE;
                    sh_valid_q <= 1'b1;
                end
                ONE: begin
                    if (push && pop) begin
                        head <= incmd;
                    end else if (push) begin
                        tail  <= incmd;
                        state <= TWO;
                    end else if (pop) begin
                        state      <= EMPTY;
                        sh_valid_q <= 1'b0;
                    end
                end
                TWO: if (pop) begin
                    head <= tail;
                    if (push) tail  <= incmd;
                    else      state <= ONE;
                end
                default: begin
                    state      <= EMPTY;
                    sh_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_accepted  <= '0;
            cnt_overrange <= '0;
        end else if (push) begin
            cnt_accepted <= cnt_accepted + cnt_width'(1);
            if (ovr) cnt_overrange <= cnt_overrange + cnt_width'(1);
        end
    end
endmodule

// File: tb/tb_lr_shift_feed.sv
// Randomised bench for lr_shift_feed against a queue-based reference model.
module tb_lr_shift_feed;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lr_shift_feed_if #(.width(8)) bus ();
    lr_shift_feed_if #(.width(8)) wb ();
    logic [15:0] cnt_acc, cnt_ovr;
    logic [3:0]  w_acc, w_ovr;

    lr_shift_feed #(.width(8), .cnt_width(16)) dut (
        .clk(clk), .rst(rst), .io(bus), .cnt_accepted(cnt_acc), .cnt_overrange(cnt_ovr));
    lr_shift_feed #(.width(8), .cnt_width(4)) dut_w (
        .clk(clk), .rst(rst), .io(wb), .cnt_accepted(w_acc), .cnt_overrange(w_ovr));

    typedef struct {
        logic [7:0] bits;
        logic [2:0] shift;
        logic       dir;
        logic [7:0] res;
    } exp_t;

    exp_t q[$];
    int checks = 0, errors = 0;
    int m_acc = 0, m_ovr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] b, input logic [3:0] s, input logic d);
        exp_t e;
        e.dir = d;
        if (s >= 4'd8) begin
            e.bits = 8'h00; e.shift = 3'd0; e.res = 8'h00;
        end else begin
            e.bits  = b;
            e.shift = s[2:0];
            e.res   = d ? (b >> s) : (b << s);
        end
        return e;
    endfunction

    // One clock cycle: drive, check mid-cycle, advance model, wait for the edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic [3:0] s,
                       input logic d, input logic r, output logic acc);
        logic pop, erdy;
        logic [7:0] gr;
        bus.in_valid = v; bus.in_bits = b; bus.in_shift = s; bus.in_dir = d;
        bus.sh_ready = r;
        #3;
        pop  = (q.size() > 0) && r;
        erdy = (q.size() < 2) || pop;
        chk("in_ready", 32'(bus.in_ready), 32'(erdy));
        chk("sh_valid", 32'(bus.sh_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("sh_bits",  32'(bus.sh_bits),  32'(q[0].bits));
            chk("sh_shift", 32'(bus.sh_shift), 32'(q[0].shift));
            chk("sh_dir",   32'(bus.sh_dir),   32'(q[0].dir));
            gr = bus.sh_dir ? (bus.sh_bits >> bus.sh_shift) : (bus.sh_bits << bus.sh_shift);
            chk("sh_result", 32'(gr), 32'(q[0].res));
        end
        chk("cnt_acc", 32'(cnt_acc), 32'(m_acc % 65536));
        chk("cnt_ovr", 32'(cnt_ovr), 32'(m_ovr % 65536));
        acc = v && erdy;
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(model(b, s, d));
            m_acc++;
            if (s >= 4'd8) m_ovr++;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic a;
        int n;
        bus.in_valid = 0; bus.in_bits = 0; bus.in_shift = 0; bus.in_dir = 0; bus.sh_ready = 0;
        wb.in_valid = 0; wb.in_bits = 0; wb.in_shift = 0; wb.in_dir = 0; wb.sh_ready = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_bits", 32'(bus.sh_bits), 32'h0);
        chk("rst_shift", 32'(bus.sh_shift), 32'h0);
        cyc(0, 8'h00, 4'd0, 0, 0, a);

        // single command
        cyc(1, 8'hA5, 4'd3, 0, 0, a);
        chk("single_valid", 32'(bus.sh_valid), 32'h1);
        chk("single_bits", 32'(bus.sh_bits), 32'hA5);
        chk("single_shift", 32'(bus.sh_shift), 32'h3);
        chk("single_obits", 32'(8'(bus.sh_bits << bus.sh_shift)), 32'h28);
        chk("single_cnt", 32'(cnt_acc), 32'h1);
        cyc(0, 8'h00, 4'd0, 0, 1, a);

        // over-range
        cyc(1, 8'hFF, 4'd8, 1, 0, a);
        chk("ovr_bits", 32'(bus.sh_bits), 32'h0);
        chk("ovr_shift", 32'(bus.sh_shift), 32'h0);
        chk("ovr_dir", 32'(bus.sh_dir), 32'h1);
        chk("ovr_cnt", 32'(cnt_ovr), 32'h1);
        cyc(0, 8'h00, 4'd0, 0, 1, a);

        // backpressure
        cyc(1, 8'h11, 4'd1, 0, 0, a);
        cyc(1, 8'h22, 4'd2, 1, 0, a);
        chk("bp_full", 32'(bus.in_ready), 32'h0);
        cyc(1, 8'h33, 4'd3, 0, 0, a);
        cyc(1, 8'h33, 4'd3, 0, 1, a);
        repeat (3) cyc(0, 8'h00, 4'd0, 0, 1, a);

        // reset with FIFO full, checked before any clock edge
        cyc(1, 8'h44, 4'd4, 0, 0, a);
        cyc(1, 8'h55, 4'd5, 1, 0, a);
        bus.in_valid = 0;
        rst = 1;
        #1;
        chk("arst_valid", 32'(bus.sh_valid), 32'h0);
        chk("arst_ready", 32'(bus.in_ready), 32'h1);
        chk("arst_acc", 32'(cnt_acc), 32'h0);
        chk("arst_ovr", 32'(cnt_ovr), 32'h0);
        q.delete(); m_acc = 0; m_ovr = 0;
        @(posedge clk); #1 rst = 0;

        // streaming
        n = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1, 8'($urandom), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1, a);
            if (a) n++;
        end
        chk("stream_thru", 32'(n), 32'd100);
        chk("stream_cnt", 32'(cnt_acc), 32'd100);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a);
        repeat (3) cyc(0, 8'h00, 4'd0, 0, 1, a);

        // counter wrap on the narrow-counter instance
        wb.in_valid = 1; wb.sh_ready = 1; wb.in_bits = 8'h5A; wb.in_shift = 4'd8; wb.in_dir = 0;
        repeat (17) @(posedge clk);
        #1 wb.in_valid = 0;
        chk("wrap_acc", 32'(w_acc), 32'h1);
        chk("wrap_ovr", 32'(w_ovr), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
